// File: rtl/memory_responder_pkg.sv
// Shared constants for the memory responder: bus width and FSM state encodings.
package memory_responder_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BUSY_RD = 3'd1;
    localparam logic [2:0] BUSY_WR = 3'd2;
    localparam logic [2:0] RESP_RD = 3'd3;
    localparam logic [2:0] RESP_WR = 3'd4;

    // Counter preload so the response appears exactly `latency` edges after acceptance.
    function automatic logic [3:0] latencyPreload(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/memory_responder_mem_array.sv
// Word storage for the memory responder: one synchronous write port, one asynchronous read port.
module mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: storage is deliberately not reset; contents must survive reset_n and a reset loop over the array would not map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Memory-side end of the CPU bus: fixed-latency read/write responder over mem_array.
// Optional MEM_PROTOCOL_CHECK_EN adds a sticky proto_err output for handshake violations.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic                 proto_err
`endif
);

    logic [2:0]            state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] addrQ;
    logic [WORD_SIZE-1:0]  wdataQ;
    logic [WORD_SIZE-1:0]  rdata;
    logic                  commit;
    logic                  unusedAddrBits;

    // Upper address bits alias onto the array.
    assign unusedAddrBits = ^address[WORD_SIZE-1:DEPTH_LOG2];

    // Commit only on the BUSY_WR -> RESP_WR edge, and never on a reset edge.
    assign commit = reset_n && (state == BUSY_WR) && writeM && (cnt == 4'd0);

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (readM) begin
                        addrQ <= address[DEPTH_LOG2-1:0];
                        cnt   <= latencyPreload(LATENCY);
                        state <= BUSY_RD;
                    end else if (writeM) begin
                        addrQ  <= address[DEPTH_LOG2-1:0];
                        wdataQ <= data;
                        cnt    <= latencyPreload(LATENCY);
                        state  <= BUSY_WR;
                    end
                end
                BUSY_RD: begin
                    if (!readM)            state <= IDLE;
                    else if (cnt == 4'd0)  state <= RESP_RD;
                    else                   cnt   <= cnt - 4'd1;
                end
                BUSY_WR: begin
                    if (!writeM)           state <= IDLE;
                    else if (cnt == 4'd0)  state <= RESP_WR;
                    else                   cnt   <= cnt - 4'd1;
                end
                RESP_RD: if (!readM)  state <= IDLE;
                RESP_WR: if (!writeM) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (WORD_SIZE)
    ) u_mem (
        .clk  (clk),
        .we   (commit),
        .waddr(addrQ),
        .wdata(wdataQ),
        .raddr(addrQ),
        .rdata(rdata)
    );

    assign inputReady = (state == RESP_RD);
    assign ackOutput  = (state == RESP_WR);
    assign data       = inputReady ? rdata : {WORD_SIZE{1'bz}};

`ifdef MEM_PROTOCOL_CHECK_EN
    logic protoViolation;

    // NOTE: default assigned first so no path through the case leaves protoViolation unassigned (no latch).
    always_comb begin
        protoViolation = 1'b0;
        case (state)
            IDLE:    protoViolation = readM && writeM;
            BUSY_RD: protoViolation = !readM || writeM;
            BUSY_WR: protoViolation = !writeM || readM;
            RESP_RD: protoViolation = writeM;
            RESP_WR: protoViolation = readM;
            default: protoViolation = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)            proto_err <= 1'b0;
        else if (protoViolation) proto_err <= 1'b1;
    end
`endif

endmodule
